// File: rtl/divider_seq.sv
// Sequential 32/32 restoring divider, signed or unsigned; 33-cycle latency (1 on divide-by-zero).
// start is ignored while busy; results are held until the next done pulse.
module divider_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;

  logic        done_q;
  logic [31:0] quot_q, remo_q;
  logic        divz_q;

  logic        accept;
  logic        load_out;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        ge;
  logic [31:0] fix_quo, fix_rem;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (divisor == 32'd0) ? FIX : CALC;
      CALC:    if (cnt_q == 6'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy     = (state_q != IDLE);
    accept   = (state_q == IDLE) && start;
    load_out = (state_q == FIX);
  end

  // One restoring step on the 33-bit partial remainder
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    ge      = (shifted >= {1'b0, dvs_q});
    diff    = shifted[31:0] - dvs_q;
    fix_quo = qneg_q ? (~quo_q + 32'd1) : quo_q;
    fix_rem = rneg_q ? (~rem_q + 32'd1) : rem_q;
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    if (accept) begin
      cnt_d = 6'd0;
      if (divisor == 32'd0) begin
        // Divide-by-zero skips CALC; FIX passes these through unchanged
        quo_d  = 32'hFFFF_FFFF;
        rem_d  = dividend;
        dvs_d  = 32'd0;
        qneg_d = 1'b0;
        rneg_d = 1'b0;
        dz_d   = 1'b1;
      end else begin
        quo_d  = (signed_op && dividend[31]) ? (~dividend + 32'd1) : dividend;
        dvs_d  = (signed_op && divisor[31])  ? (~divisor + 32'd1)  : divisor;
        rem_d  = 32'd0;
        qneg_d = signed_op && (dividend[31] ^ divisor[31]);
        rneg_d = signed_op && dividend[31];
        dz_d   = 1'b0;
      end
    end else if (state_q == CALC) begin
      rem_d = ge ? diff : shifted[31:0];
      quo_d = {quo_q[30:0], ge};
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvs_q  <= 32'd0;
      cnt_q  <= 6'd0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
      quot_q <= 32'd0;
      remo_q <= 32'd0;
      divz_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      done_q <= load_out;
      if (load_out) begin
        quot_q <= fix_quo;
        remo_q <= fix_rem;
        divz_q <= dz_q;
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign div_zero  = divz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed and random checks of divider_seq against an arithmetic reference model.
module tb_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  divider_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero when signed
  function automatic void model(input logic sop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    int sa, sb;
    dz = 1'b0;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (!sop) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end
  endfunction

  // poke >= 0: pulse start with 5/5 while busy, that many cycles after acceptance
  task automatic run_op(input logic sop, input logic [31:0] a, input logic [31:0] b, input int poke);
    logic [31:0] eq, er, pq, pr;
    logic        edz, pdz;
    int          lat;
    model(sop, a, b, eq, er, edz);
    pq  = quotient;
    pr  = remainder;
    pdz = div_zero;
    @(negedge clk);
    start     = 1'b1;
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    signed_op = 1'($urandom_range(0, 1));
    dividend  = $urandom;
    divisor   = $urandom;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      chk("busy_high", 32'(busy), 32'd1);
      chk("quo_hold", quotient, pq);
      chk("rem_hold", remainder, pr);
      chk("dz_hold", 32'(div_zero), 32'(pdz));
      if (lat == poke) begin
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", 32'(lat), (b == 32'd0) ? 32'd1 : 32'd33);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_zero", 32'(div_zero), 32'(edz));
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
    chk("quo_kept", quotient, eq);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          sel;
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quo", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    rst_n = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, -1);
    // -7/2 truncates toward zero: -3 remainder -1
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(1'b0, 32'h0000_1234, 32'd0, -1);
    run_op(1'b1, 32'hFFFF_FF00, 32'd0, -1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, -1);
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9, -1);
    run_op(1'b0, 32'd1000, 32'd3, 10);

    // Reset mid-operation, with start asserted on the reset edge
    @(negedge clk);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd4;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quo", quotient, 32'd0);
    chk("abort_rem", remainder, 32'd0);
    chk("abort_dz", 32'(div_zero), 32'd0);
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      chk("no_done_after_abort", 32'(done), 32'd0);
    end
    run_op(1'b0, 32'd9, 32'd4, -1);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      ra  = (sel == 7) ? 32'h8000_0000 : $urandom;
      if (sel == 0)      rb = 32'd0;
      else if (sel <= 3) rb = $urandom_range(1, 15);
      else if (sel == 4) rb = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1;
      else               rb = $urandom;
      run_op(1'($urandom_range(0, 1)), ra, rb, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
